// File: rtl/larpix_config_master.sv
// Host-side LArPix configuration master: turns register commands into 64-bit
// odd-parity config packets and matches read replies coming back from the chip.
module larpix_config_master #(
  parameter int          WIDTH          = 64,
  parameter logic [31:0] MAGIC_NUMBER   = 32'h89_50_4E_47,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          TIMEOUT_BITS   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_chip_id,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  output logic [WIDTH-1:0] tx_packet,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_packet,
  input  logic             rx_valid,
  output logic             rsp_valid,
  output logic [1:0]       rsp_status,
  output logic [7:0]       rsp_data,
  output logic [1:0]       rsp_fifo_flags,
  output logic [11:0]      bad_packets,
  output logic [11:0]      stray_packets
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

  localparam logic [TIMEOUT_BITS-1:0] LP_CNT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0]             LP_SAT      = 12'hFFF;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_write;
  logic [7:0]              r_chip;
  logic [7:0]              r_addr;
  logic [TIMEOUT_BITS-1:0] r_cnt;
  logic [WIDTH-1:0]        r_tx_packet;
  logic [1:0]              r_rsp_status;
  logic [7:0]              r_rsp_data;
  logic [1:0]              r_rsp_flags;
  logic [11:0]             r_bad;
  logic [11:0]             r_stray;

  logic                    w_par_ok;
  logic                    w_match;
  logic                    w_consumed;
  logic [TIMEOUT_BITS-1:0] w_cnt_next;
  logic                    w_timeout;

  // Odd parity over the whole packet means the XOR of all bits is one.
  function automatic logic parity_ok(input logic [WIDTH-1:0] p);
    return ^p;
  endfunction

  function automatic logic [WIDTH-1:0] build_packet(input logic       wr,
                                                    input logic [7:0] chip,
                                                    input logic [7:0] addr,
                                                    input logic [7:0] data);
    logic [WIDTH-1:0] p;
    p          = '0;
    p[1:0]     = wr ? 2'b10 : 2'b11;
    p[9:2]     = chip;
    p[17:10]   = addr;
    p[25:18]   = wr ? data : 8'h00;
    p[57:26]   = MAGIC_NUMBER;
    p[WIDTH-1] = ~^p[WIDTH-2:0];
    return p;
  endfunction

  assign w_par_ok   = parity_ok(rx_packet);
  assign w_match    = rx_valid && w_par_ok && (rx_packet[1:0] == 2'b11) &&
                      (rx_packet[9:2] == r_chip) && (rx_packet[17:10] == r_addr) &&
                      (rx_packet[57:26] == MAGIC_NUMBER);
  assign w_consumed = (r_state == S_WAIT) && w_match;
  // Timeout fires on the cycle the counter steps onto its last value, so the
  // response lands exactly TIMEOUT_CYCLES cycles after the TX handshake.
  assign w_cnt_next = r_cnt + TIMEOUT_BITS'(1);
  assign w_timeout  = (w_cnt_next == LP_CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_SEND;
      S_SEND: if (tx_ready)  w_next = r_write ? S_RESP : S_WAIT;
      S_WAIT: if (w_match || w_timeout) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE) && !reset;
    tx_valid  = (r_state == S_SEND) && !reset;
    rsp_valid = (r_state == S_RESP) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_chip       <= 8'h00;
      r_addr       <= 8'h00;
      r_cnt        <= '0;
      r_tx_packet  <= '0;
      r_rsp_status <= 2'b00;
      r_rsp_data   <= 8'h00;
      r_rsp_flags  <= 2'b00;
      r_bad        <= 12'h000;
      r_stray      <= 12'h000;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_write     <= cmd_write;
        r_chip      <= cmd_chip_id;
        r_addr      <= cmd_addr;
        r_tx_packet <= build_packet(cmd_write, cmd_chip_id, cmd_addr, cmd_wdata);
      end
      if (r_state == S_SEND && tx_ready) begin
        r_cnt <= '0;
        if (r_write) begin
          r_rsp_status <= 2'b00;
          r_rsp_data   <= 8'h00;
          r_rsp_flags  <= 2'b00;
        end
      end
      if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_next;
        if (w_match) begin
          r_rsp_status <= 2'b00;
          r_rsp_data   <= rx_packet[25:18];
          r_rsp_flags  <= rx_packet[61:60];
        end else if (w_timeout) begin
          r_rsp_status <= 2'b01;
          r_rsp_data   <= 8'h00;
          r_rsp_flags  <= 2'b00;
        end
      end
      if (rx_valid && !w_par_ok && r_bad != LP_SAT)
        r_bad <= r_bad + 12'd1;
      if (rx_valid && w_par_ok && !w_consumed && r_stray != LP_SAT)
        r_stray <= r_stray + 12'd1;
    end
  end

  assign tx_packet      = r_tx_packet;
  assign rsp_status     = r_rsp_status;
  assign rsp_data       = r_rsp_data;
  assign rsp_fifo_flags = r_rsp_flags;
  assign bad_packets    = r_bad;
  assign stray_packets  = r_stray;

endmodule

// File: doc/larpix_config_master.md
# larpix_config_master

Host-side configuration master for the LArPix Hydra UART network, sitting on the controller/FPGA end of a chip's serial link. It turns register write/read commands into 64-bit parity-protected configuration packets for the UART transmitter. For reads, it waits for the chip's reply from the UART receiver, checks it, and returns the register byte plus the chip's FIFO flags. It also detects timeouts and keeps counters of bad and stray packets.

## Interface
- `WIDTH`, 64, packet width including the parity bit (bit `WIDTH-1`).
- `MAGIC_NUMBER`, 32'h89_50_4E_47, required in bits [57:26] of every config packet.
- `TIMEOUT_CYCLES`, 4096, clk cycles to wait for a read reply.
- `TIMEOUT_BITS`, 12, timeout counter width (must hold `TIMEOUT_CYCLES-1`).
- `clk`  input  1  master clock.
- `reset`  input  1  reset, synchronous, active-high.
- `cmd_valid`  input  1  command request.
- `cmd_ready`  output  1  high when a command can be accepted.
- `cmd_write`  input  1  1 = register write, 0 = register read.
- `cmd_chip_id`  input  8  target chip id.
- `cmd_addr`  input  8  register address.
- `cmd_wdata`  input  8  write data (ignored for reads).
- `tx_packet`  output  64  packet to the UART TX.
- `tx_valid`  output  1  `tx_packet` valid.
- `tx_ready`  input  1  UART TX can accept (not busy).
- `rx_packet`  input  64  packet from the UART RX.
- `rx_valid`  input  1  one-cycle strobe, `rx_packet` valid.
- `rsp_valid`  output  1  one-cycle response strobe.
- `rsp_status`  output  2  00 ok, 01 timeout, 10 reserved, 11 reserved.
- `rsp_data`  output  8  read data (0 for writes or timeouts).
- `rsp_fifo_flags`  output  2  {fifo_full, fifo_half} from reply bits [61:60].
- `bad_packets`  output  12  saturating count of received packets with parity errors.
- `stray_packets`  output  12  saturating count of good-parity packets not consumed as a reply.

## Operation
- Packet fields:
  - [1:0] type: 10 = config write, 11 = config read.
  - [9:2] chip_id.
  - [17:10] address.
  - [25:18] data.
  - [57:26] `MAGIC_NUMBER`.
  - [62:58] zero on transmit, ignored on receive.
  - [63] odd parity: `~^packet[62:0]`.
- Outgoing read packets carry data = 0.
- FSM states: IDLE, SEND, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch the command, build the packet, and go to SEND.
- SEND:
  - `tx_valid`=1 and `tx_packet` held stable.
  - On `tx_ready`, a write goes to RESP with status ok.
  - On `tx_ready`, a read clears the timeout counter and goes to WAIT.
- WAIT:
  - The counter increments every cycle.
  - A matching reply goes to RESP with status ok and captures [25:18] and [61:60].
  - A matching reply has good parity, type 11, chip_id = latched id, address = latched address, and magic = `MAGIC_NUMBER`.
  - A reply matches regardless of bits [62:58].
  - When the counter reaches `TIMEOUT_CYCLES-1` with no match, go to RESP with status timeout, data 0, flags 0.
- RESP: `rsp_valid`=1 for exactly one cycle, then return to IDLE.
- Every `rx_valid` with bad parity increments `bad_packets`, in any state.
- A good-parity packet that is not a matching reply increments `stray_packets`, in any state.
- Counters saturate at 12'hFFF.

## Timing
- Reset values:
  - State is IDLE.
  - `cmd_ready`=0 during the reset cycle, then 1.
  - `tx_valid`=0 and `tx_packet`=0.
  - `rsp_valid`=0, `rsp_status`=0, `rsp_data`=0, `rsp_fifo_flags`=0.
  - `bad_packets`=0 and `stray_packets`=0.
  - Timeout counter = 0.
- Reset mid-operation abandons the transaction and emits no response.
- Command accept occurs in cycle N; `tx_valid` rises in N+1.
- Write: TX handshake in cycle M gives `rsp_valid` in M+1. Minimum write latency is 2 cycles from accept to response.
- Read: a match sampled in cycle K gives `rsp_valid` in K+1.
- If the match arrives in the same cycle the counter hits `TIMEOUT_CYCLES-1`, the match wins (status ok).
- `rsp_*` fields hold their values until the next response; only `rsp_valid` pulses.
- `cmd_ready` is 0 from SEND through RESP; `cmd_valid` in those states is ignored, not queued.
- `rx_valid` during SEND is checked but cannot match, because the packet has not yet been sent.

## Test plan
- Write: chip 8'h05, addr 8'h20, data 8'hA5.
  - `tx_packet` = {1'b?, 5'b0, 32'h89504E47, 8'hA5, 8'h20, 8'h05, 2'b10} with the odd-parity bit correct.
  - `rsp_valid` 1 cycle after `tx_ready`, status 00.
- Read: chip 8'h05, addr 8'h10; a good reply with data 8'h3C and bits[61:60] = 2'b10 arrives 100 cycles later.
  - `rsp_status`=00, `rsp_data`=8'h3C, `rsp_fifo_flags`=2'b10.
- Read with no reply and `TIMEOUT_CYCLES`=16.
  - `rsp_status`=01 exactly 16 cycles after the TX handshake.
  - `rsp_data`=0.
- During WAIT, inject a reply with a flipped parity bit, then one with chip_id 8'h06, then the correct reply.
  - `bad_packets`=1 and `stray_packets`=1.
  - Response ok with the correct data.
- `tx_ready` held low for 50 cycles during SEND.
  - `tx_valid`/`tx_packet` stable throughout.
  - The timeout counter does not run.
  - `cmd_ready`=0.
- Assert `reset` in WAIT.
  - Next cycle: IDLE, counters 0, no `rsp_valid`.
  - A late reply afterwards counts as stray.
- Force 4100 bad packets: `bad_packets` saturates at 12'hFFF.
